// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, transmit state encoding and baud divisor.
// The receiver uses the same calc_baud_max so both ends derive an identical bit time.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  // Clocks per bit; integer division, so the real baud rate rounds up slightly.
  function automatic int calc_baud_max(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-time counter: counts 0..CNT_MAX-1 while enabled; tick on the last clock of each bit, no latency.
// No backpressure; clr has priority over counting.
module uart_baud_cnt #(
  parameter int CNT_MAX = 10,
  parameter int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             tick
);

  assign tick = en && (cnt == CNT_W'(CNT_MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8 data bits, optional parity, 1 or 2 stop bits; start bit one clock after accept.
// Single-entry valid/ready: a request while tx_ready is low is ignored, never buffered.
module uart_tx
  import uart_pkg::*;
#(
  parameter int UART_BPS  = 9600,
  parameter int CLK_FREQ  = 50_000_000,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] pi_data,
  input  logic       pi_flag,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx
);

  localparam int BAUD_CNT_MAX = calc_baud_max(CLK_FREQ, UART_BPS);
  localparam int CNT_W        = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;

  if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_parity
    $error("uart_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (BAUD_CNT_MAX < 2) begin : g_bad_baud
    $error("uart_tx: CLK_FREQ/UART_BPS must be at least 2");
  end

  tx_state_t        state;
  logic [7:0]       shift_reg;
  logic             par_bit;
  logic [2:0]       bit_cnt;
  logic             stop_cnt;
  logic [CNT_W-1:0] baud_cnt;
  logic             baud_tick;
  logic             accept;
  logic             stop_final;
  logic             stop_near_end;

  uart_baud_cnt #(
    .CNT_MAX (BAUD_CNT_MAX),
    .CNT_W   (CNT_W)
  ) u_baud_cnt (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .en    (state != ST_IDLE),
    .clr   (state == ST_IDLE),
    .cnt   (baud_cnt),
    .tick  (baud_tick)
  );

  assign accept     = pi_flag && tx_ready;
  assign stop_final = (stop_cnt == 1'(STOP_BITS - 1));
  // ready/done are registered, so they are raised one clock before the final stop clock.
  assign stop_near_end = (state == ST_STOP) && stop_final &&
                         (baud_cnt == CNT_W'(BAUD_CNT_MAX - 2));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      par_bit   <= 1'b0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      tx        <= 1'b1;
      tx_ready  <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (accept) begin
        shift_reg <= pi_data;
        par_bit   <= (PARITY == PAR_ODD) ? ~^pi_data : ^pi_data;
        bit_cnt   <= '0;
        stop_cnt  <= 1'b0;
        state     <= ST_START;
        tx        <= 1'b0;
        tx_busy   <= 1'b1;
        tx_ready  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            tx <= 1'b1;
          end
          ST_START: begin
            if (baud_tick) begin
              state     <= ST_DATA;
              tx        <= shift_reg[0];
              shift_reg <= {1'b0, shift_reg[7:1]};
            end
          end
          ST_DATA: begin
            if (baud_tick) begin
              if (bit_cnt == 3'd7) begin
                if (PARITY != PAR_NONE) begin
                  state <= ST_PARITY;
                  tx    <= par_bit;
                end else begin
                  state <= ST_STOP;
                  tx    <= 1'b1;
                end
              end else begin
                bit_cnt   <= bit_cnt + 3'd1;
                tx        <= shift_reg[0];
                shift_reg <= {1'b0, shift_reg[7:1]};
              end
            end
          end
          ST_PARITY: begin
            if (baud_tick) begin
              state <= ST_STOP;
              tx    <= 1'b1;
            end
          end
          ST_STOP: begin
            if (stop_near_end) begin
              tx_ready <= 1'b1;
              tx_done  <= 1'b1;
            end
            if (baud_tick) begin
              if (stop_final) begin
                state   <= ST_IDLE;
                tx_busy <= 1'b0;
              end else begin
                stop_cnt <= 1'b1;
              end
            end
          end
          default: begin
            state <= ST_IDLE;
            tx    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
